// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus arbiter.
//   - arb_state_e : arbiter FSM encoding, also driven on state_out
//   - SlaveIdW    : slave ID width, shared with the slave-side FSM
//   - owner_enc() : builds owner_id (bit 3 = slave flag, bits 2:0 = index)
package bus_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrantM  = 2'd1,
    StGrantS  = 2'd2,
    StRelease = 2'd3
  } arb_state_e;

  localparam int unsigned SlaveIdW  = 3;
  localparam int unsigned OwnerW    = SlaveIdW + 1;
  localparam int unsigned StateOutW = 3;

  function automatic logic [OwnerW-1:0] owner_enc(input logic                is_slave,
                                                  input logic [SlaveIdW-1:0] idx);
    return {is_slave, idx};
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index with highest priority; search wraps modulo Width
//   gnt   : one-hot grant (all zero when nothing is requested)
//   valid : at least one request present
module rr_priority_picker #(
  parameter int unsigned Width = 3,
  localparam int unsigned PtrW = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req,
  input  logic [PtrW-1:0]  ptr,
  output logic [Width-1:0] gnt,
  output logic             valid
);

  logic [Width-1:0] mask;
  logic [Width-1:0] hi_req;

  always_comb begin
    // Requests at or above ptr win; otherwise wrap to the lowest request overall.
    mask   = ~((Width'(1) << ptr) - Width'(1));
    hi_req = req & mask;
    // x & -x isolates the lowest set bit.
    gnt    = (|hi_req) ? (hi_req & (~hi_req + Width'(1))) : (req & (~req + Width'(1)));
    valid  = |req;
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Central arbiter for the shared single-wire serial bus.
// Slaves with return data (s_ready) always beat masters; masters are served
// round robin. A release cycle with a bus_util pulse separates tenures.
// Optional macro ARB_TIMEOUT_EN: force a release after TIMEOUT_CYCLES tenure
// cycles and set the sticky timeout_err flag.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   m_req       : per-master level request
//   m_done      : per-master tenure-end pulse (ignored unless owner)
//   s_ready     : per-slave level, needs a return tenure
//   s_done      : per-slave tenure-end pulse (ignored unless owner)
//   m_grant     : one-hot master grant (registered)
//   s_cmd       : one-hot slave command, drives arbiter_cmd_in (registered)
//   bus_util    : one-cycle release pulse
//   owner_id    : {slave flag, index}; 0 when nobody owns the bus
//   timeout_err : sticky forced-release flag
//   state_out   : current FSM state
module serial_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned NUM_SLAVES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_done,
  input  logic [NUM_SLAVES-1:0]  s_ready,
  input  logic [NUM_SLAVES-1:0]  s_done,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_SLAVES-1:0]  s_cmd,
  output logic                   bus_util,
  output logic [OwnerW-1:0]      owner_id,
  output logic                   timeout_err,
  output logic [StateOutW-1:0]   state_out
);

  localparam int unsigned PtrW = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 2**SlaveIdW || NUM_SLAVES > 2**SlaveIdW ||
      TIMEOUT_CYCLES < 4 || 2**TIMEOUT_WIDTH <= TIMEOUT_CYCLES) begin : g_bad_params
    $error("serial_bus_arbiter: illegal parameter combination");
  end

  arb_state_e             state_q, state_d;
  logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d, rr_next;
  logic [NUM_MASTERS-1:0] m_grant_q, m_grant_d, m_pick;
  logic [NUM_SLAVES-1:0]  s_cmd_q, s_cmd_d, s_pick;
  logic [OwnerW-1:0]      owner_q, owner_d;
  logic                   bus_util_q, bus_util_d;
  logic [SlaveIdW-1:0]    m_idx, s_idx;
  logic                   m_valid, own_done, timeout;

  rr_priority_picker #(
    .Width(NUM_MASTERS)
  ) u_m_picker (
    .req  (m_req),
    .ptr  (rr_ptr_q),
    .gnt  (m_pick),
    .valid(m_valid)
  );

  // Lowest-index slave wins.
  assign s_pick = s_ready & (~s_ready + NUM_SLAVES'(1));

  // Done pulses only count from the current owner; grants are zero outside tenures.
  assign own_done = (|(m_done & m_grant_q)) | (|(s_done & s_cmd_q));

  // One-hot to index conversion, plus the pointer value past the current master.
  always_comb begin
    m_idx   = '0;
    s_idx   = '0;
    rr_next = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (m_pick == (NUM_MASTERS'(1) << i)) m_idx = SlaveIdW'(i);
      if (m_grant_q == (NUM_MASTERS'(1) << i)) begin
        rr_next = (i == int'(NUM_MASTERS) - 1) ? '0 : PtrW'(i + 1);
      end
    end
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (s_pick == (NUM_SLAVES'(1) << i)) s_idx = SlaveIdW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    m_grant_d  = m_grant_q;
    s_cmd_d    = s_cmd_q;
    owner_d    = owner_q;
    bus_util_d = 1'b0;
    unique case (state_q)
      StGrantM, StGrantS: begin
        if (own_done || timeout) begin
          state_d    = StRelease;
          m_grant_d  = '0;
          s_cmd_d    = '0;
          owner_d    = '0;
          bus_util_d = 1'b1;
          // Slave tenures leave the master rotation untouched.
          if (state_q == StGrantM) rr_ptr_d = rr_next;
        end
      end
      default: begin
        // StIdle and StRelease are both arbitration points.
        state_d   = StIdle;
        m_grant_d = '0;
        s_cmd_d   = '0;
        owner_d   = '0;
        if (|s_ready) begin
          state_d = StGrantS;
          s_cmd_d = s_pick;
          owner_d = owner_enc(1'b1, s_idx);
        end else if (m_valid) begin
          state_d   = StGrantM;
          m_grant_d = m_pick;
          owner_d   = owner_enc(1'b0, m_idx);
        end
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     in_tenure;

  assign in_tenure = (state_q == StGrantM) || (state_q == StGrantS);
  // Counter reads k-1 in the k-th tenure cycle, so the tenure lasts TIMEOUT_CYCLES.
  assign timeout   = in_tenure && (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign err_d     = err_q | (timeout & ~own_done);

  always_comb begin
    cnt_d = cnt_q;
    if (!in_tenure) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      m_grant_q  <= '0;
      s_cmd_q    <= '0;
      owner_q    <= '0;
      bus_util_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      m_grant_q  <= m_grant_d;
      s_cmd_q    <= s_cmd_d;
      owner_q    <= owner_d;
      bus_util_q <= bus_util_d;
    end
  end

  assign m_grant   = m_grant_q;
  assign s_cmd     = s_cmd_q;
  assign owner_id  = owner_q;
  assign bus_util  = bus_util_q;
  assign state_out = StateOutW'(state_q);

endmodule
